// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes
// in {g,f,e,d,c,b,a} order (bit 6 = g, bit 0 = a).
package seg7_scan_driver_pkg;

    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit inputs from the counter chain and display pin outputs of the scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic                    lz_blank;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output digits, dp_en, lz_blank,
        input  seg, dp, an, digit_idx, frame_tick
    );

    modport slave (
        input  digits, dp_en, lz_blank,
        output seg, dp, an, digit_idx, frame_tick
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decode; codes A..F show a dash.
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame snapshot, slot prescaler,
// anti-ghost blanking, leading-zero suppression and registered pin outputs.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);

    logic [PRESC_W-1:0]      presc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic                    snap_lz_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_tick_q;

    logic [3:0]              digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:1]   upper_zero;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_seg;
    logic                    presc_last;
    logic                    idx_last;
    logic                    frame_start;
    logic                    shown;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = snap_digits_q[4*gi +: 4];
        end

        // A digit is a leading zero when it and every more significant digit are zero.
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (digit_arr[gi] == 4'd0);
            end else begin : g_mid
                assign upper_zero[gi] = (digit_arr[gi] == 4'd0) && upper_zero[gi+1];
            end
            assign blank_mask[gi] = snap_lz_q && upper_zero[gi];
        end
    endgenerate

    assign blank_mask[0] = 1'b0;

    assign presc_last  = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_start = (presc_q == '0) && (idx_q == '0);
    assign cur_digit   = digit_arr[idx_q];
    assign shown       = (presc_q >= PRESC_W'(BLANK_CYC)) && !blank_mask[idx_q];

    bcd_to_seg7 u_decode (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Slot 0 of each frame always starts blanked, so decoding the old
    // snapshot on the load cycle never reaches the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            if (presc_last) begin
                presc_q <= '0;
                idx_q   <= idx_last ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end

            if (frame_start) begin
                snap_digits_q <= bus.digits;
                snap_dp_q     <= bus.dp_en;
                snap_lz_q     <= bus.lz_blank;
            end

            frame_tick_q <= frame_start;
            seg_q        <= shown ? cur_seg : SEG_OFF;
            dp_q         <= shown ? ~snap_dp_q[idx_q] : 1'b1;
            an_q         <= shown ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.digit_idx  = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level model predicts every
// output cycle, a negedge monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 1;

    typedef struct {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic [1:0]   idx;
        logic         ft;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp     = '0;
    logic        m_lz     = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .BLANK_CYC  (B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic exp_t off_exp();
        exp_t e;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.an  = '1;
        e.idx = '0;
        e.ft  = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position from cycles since reset release.
    initial begin
        forever begin
            int   presc;
            int   idx;
            int   dig;
            logic shown;
            exp_t e;
            @(posedge clk);
            if (!reset) begin
                cyc = 0;
                sb.push_back(off_exp());
            end else begin
                presc = cyc % S;
                idx   = (cyc / S) % N;
                if (presc == 0 && idx == 0) begin
                    m_digits = bus.digits;
                    m_dp     = bus.dp_en;
                    m_lz     = bus.lz_blank;
                end
                dig   = int'((m_digits >> (4 * idx)) & 16'hF);
                shown = (presc >= B) && !(idx > 0 && m_lz && (m_digits >> (4 * idx)) == 16'd0);
                e.ft  = (presc == 0 && idx == 0);
                e.idx = 2'(((cyc + 1) / S) % N);
                e.seg = shown ? ref_seg(dig) : 7'h7F;
                e.an  = shown ? ~(4'b0001 << idx) : 4'hF;
                e.dp  = shown ? ~m_dp[idx] : 1'b1;
                sb.push_back(e);
                cyc = (cyc + 1) % (N * S);
            end
        end
    end

    // Asynchronous reset discards predictions made for the interrupted cycle.
    initial begin
        forever begin
            @(negedge reset);
            sb.delete();
            cyc = 0;
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("seg",        16'(bus.seg),        16'(e.seg));
                chk("dp",         16'(bus.dp),         16'(e.dp));
                chk("an",         16'(bus.an),         16'(e.an));
                chk("digit_idx",  16'(bus.digit_idx),  16'(e.idx));
                chk("frame_tick", 16'(bus.frame_tick), 16'(e.ft));
                $display("t=%0t an=%b seg=%b dp=%b idx=%0d ft=%b", $time,
                         bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dpe, input logic lz);
        bus.digits   = d;
        bus.dp_en    = dpe;
        bus.lz_blank = lz;
    endtask

    task automatic wait_idx2(input string name);
        int k;
        k = 0;
        while (bus.digit_idx != 2'd2 && k < 64) begin
            step(1);
            k++;
        end
        if (k >= 64) begin
            errors++;
            $display("FAIL %s: timeout waiting for digit_idx=2 got %0d", name, bus.digit_idx);
        end
    endtask

    initial begin
        set_in(16'h1234, 4'b0000, 1'b0);
        step(3);
        chk("reset_an", 16'(bus.an), 16'hF);
        chk("reset_ft", 16'(bus.frame_tick), 16'h0);
        reset = 1'b1;
        step(32);

        set_in(16'h0050, 4'b0000, 1'b1);
        step(32);
        set_in(16'h0000, 4'b0000, 1'b1);
        step(32);

        set_in(16'h1234, 4'b0000, 1'b0);
        step(16);
        wait_idx2("sync_idx2_a");
        set_in(16'h9876, 4'b0000, 1'b0);
        step(32);

        set_in(16'h00B0, 4'b0010, 1'b0);
        step(32);

        repeat (40) begin
            logic [15:0] d;
            d = 16'($urandom_range(0, 65535));
            d = d >> (4 * $urandom_range(0, 4));
            set_in(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step($urandom_range(1, 20));
        end

        set_in(16'h4321, 4'b0100, 1'b0);
        step(16);
        wait_idx2("sync_idx2_b");
        step(1);
        #1 reset = 1'b0;
        #1;
        chk("async_an",  16'(bus.an),  16'hF);
        chk("async_seg", 16'(bus.seg), 16'h7F);
        chk("async_dp",  16'(bus.dp),  16'h1);
        step(2);
        reset = 1'b1;
        step(1);
        chk("restart_idx", 16'(bus.digit_idx),  16'h0);
        chk("restart_ft",  16'(bus.frame_tick), 16'h1);
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Display-side consumer for the BCD digit counters. It takes NUM_DIGITS packed BCD digits, snapshots them once per frame and time-multiplexes them onto a common-segment 7-segment display. It owns the refresh prescaler, the digit-select rotation, the anti-ghost blanking and the segment decode, and sits between the counter chain and the board pins.

Parameters:
NUM_DIGITS, 4, digits scanned; digit 0 is least significant; legal range 2..8
SCAN_DIV, 50000, clk cycles per digit slot; must be at least 2
BLANK_CYC, 500, leading cycles of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < SCAN_DIV

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
digits  in  4*NUM_DIGITS  packed BCD; digit i occupies bits [4i+3:4i]
dp_en  in  NUM_DIGITS  decimal point enable per digit
lz_blank  in  1  1 = leading-zero blanking enabled
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
dp  out  1  decimal point, active-low, registered
an  out  NUM_DIGITS  digit anodes, active-low one-hot or all-off, registered
digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
frame_tick  out  1  one-cycle pulse on the cycle the snapshot loads

Behaviour:
- Reset (reset=0, asynchronous): presc=0, idx=0, snap=0, seg=all 1, dp=1, an=all 1, frame_tick=0.
- Prescaler: presc counts 0..SCAN_DIV-1. At SCAN_DIV-1, presc wraps to 0 and idx advances. idx wraps NUM_DIGITS-1 -> 0.
- Snapshot: on any cycle with presc==0 and idx==0, snap <= {digits, dp_en, lz_blank} and frame_tick=1.
- This condition also holds on the first cycle after reset release. Input changes mid-frame are invisible until the next frame.
- Outputs are registered with 1-cycle latency from (presc, idx, snap).
- If presc < BLANK_CYC, an=all 1 and seg/dp are off.
- Otherwise, an is one-hot low at bit idx, unless digit idx is blanked, in which case an=all 1.
- Leading-zero blanking: digit i>0 is blanked when snapped lz_blank=1 and snap digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- Decode, active-low {g..a}:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Codes A..F display a dash: seg=0111111.
- dp = ~snap dp_en[idx] while the digit is displayed, else 1.
- digit_idx = idx, combinational from the register.
- Frame period = NUM_DIGITS*SCAN_DIV cycles exactly; there are no idle cycles.
- Reset mid-scan: outputs go off immediately. After release, the scan restarts at idx 0 with a fresh snapshot.

Decomposition:
- Shared package: 7-bit segment constants for 0-9 and the dash; SEG_OFF=7'h7F; the {g,f,e,d,c,b,a} ordering.
- One sub-module: bcd_to_seg7 (combinational 4-bit to 7-bit decode, active-low), instantiated once on the muxed snapshot digit.
- Prescaler, index, snapshot, blanking and output registers stay in the top module.

Test Plan:
Bench settings: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
1. Hold reset=0 with digits=16'h1234 -> an=1111, seg=1111111, dp=1, frame_tick=0. Release -> frame_tick=1 on the first cycle; in cycles 2..4, an=1110 and seg=0011001 ('4').
2. digits=16'h1234, lz_blank=0, free-run 16 cycles -> anodes step 1110, 1101, 1011, 0111 with seg 0011001, 0110000, 0100100, 1111001. Each slot shows one blank cycle first. frame_tick recurs every 16 cycles.
3. lz_blank=1, digits=16'h0050 -> slots 3 and 2 keep an=1111; slot 1 shows 0010010; slot 0 shows 1000000. With digits=16'h0000, only slot 0 lights, with 1000000.
4. Change digits from 16'h1234 to 16'h9876 while idx=2 -> the remaining slots still show 3 and 4's frame values ('2','1'). The next frame, after frame_tick, shows 9876.
5. digits=16'h00B0, lz_blank=0, dp_en=4'b0010 -> slot 1 shows seg=0111111 and dp=0; all other slots have dp=1.
6. Assert reset=0 mid-slot at idx=2 -> an=1111 asynchronously, before the next clk edge. After release, digit_idx=0 and frame_tick=1.
